// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VGA raster timing generator. The raster position advances on
// system-clock cycles where `en` (pixel tick) is high; all outputs are
// registered decodes of the position held before that tick.
//
// Optional feature: define VGA_TIMING_FRAMECNT_EN to add the 16-bit
// `frame_cnt` output (first frame after reset reads 0).
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   en           pixel tick enable
//   hsync/vsync  sync outputs, level during sync = HSYNC_POL / VSYNC_POL
//   de           display enable (h and v both in Display)
//   x, y         active-area coordinates, 0 outside Display
//   h_state      horizontal phase (0 Sync, 1 BackPorch, 2 Display, 3 FrontPorch)
//   v_state      vertical phase, same encoding
//   line_start   one-clk strobe on the first tick of each line
//   frame_start  one-clk strobe on the first tick of each frame
//   frame_cnt    frame counter (VGA_TIMING_FRAMECNT_EN only)
//
// Phase | meaning
// 0     | Sync
// 1     | BackPorch
// 2     | Display
// 3     | FrontPorch
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [1:0]    h_state,
    output logic [1:0]    v_state,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_TIMING_FRAMECNT_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    localparam logic [1:0] PH_SYNC = 2'd0;
    localparam logic [1:0] PH_BP   = 2'd1;
    localparam logic [1:0] PH_DISP = 2'd2;
    localparam logic [1:0] PH_FP   = 2'd3;

    // Counters sized for the longest segment; +1 keeps width >= 1 when all
    // segments are a single tick.
    localparam int H_M0  = (H_SYNC > H_BP) ? H_SYNC : H_BP;
    localparam int H_M1  = (H_ACTIVE > H_FP) ? H_ACTIVE : H_FP;
    localparam int H_MAX = (H_M0 > H_M1) ? H_M0 : H_M1;
    localparam int V_M0  = (V_SYNC > V_BP) ? V_SYNC : V_BP;
    localparam int V_M1  = (V_ACTIVE > V_FP) ? V_ACTIVE : V_FP;
    localparam int V_MAX = (V_M0 > V_M1) ? V_M0 : V_M1;
    localparam int HCW   = $clog2(H_MAX + 1);
    localparam int VCW   = $clog2(V_MAX + 1);

    logic [1:0]     h_ph, v_ph;
    logic [HCW-1:0] hc;
    logic [VCW-1:0] vc;
    logic           h_last, v_last;
    logic           at_line_start, at_frame_start;

    always_comb begin
        h_last = 1'b0;
        case (h_ph)
            PH_SYNC: h_last = (hc == HCW'(H_SYNC - 1));
            PH_BP:   h_last = (hc == HCW'(H_BP - 1));
            PH_DISP: h_last = (hc == HCW'(H_ACTIVE - 1));
            default: h_last = (hc == HCW'(H_FP - 1));
        endcase
    end

    always_comb begin
        v_last = 1'b0;
        case (v_ph)
            PH_SYNC: v_last = (vc == VCW'(V_SYNC - 1));
            PH_BP:   v_last = (vc == VCW'(V_BP - 1));
            PH_DISP: v_last = (vc == VCW'(V_ACTIVE - 1));
            default: v_last = (vc == VCW'(V_FP - 1));
        endcase
    end

    assign at_line_start  = (h_ph == PH_SYNC) && (hc == '0);
    assign at_frame_start = at_line_start && (v_ph == PH_SYNC) && (vc == '0);

`ifdef VGA_TIMING_FRAMECNT_EN
    logic first_frame;

    // The first frame after reset is frame 0, so its start does not count.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_frame <= 1'b1;
            frame_cnt   <= 16'd0;
        end else if (en && at_frame_start) begin
            if (first_frame) begin
                first_frame <= 1'b0;
            end else begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            h_ph        <= PH_SYNC;
            v_ph        <= PH_SYNC;
            hc          <= '0;
            vc          <= '0;
            hsync       <= HSYNC_POL;
            vsync       <= VSYNC_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            h_state     <= PH_SYNC;
            v_state     <= PH_SYNC;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (en) begin
                hsync       <= (h_ph == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
                vsync       <= (v_ph == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
                de          <= (h_ph == PH_DISP) && (v_ph == PH_DISP);
                x           <= (h_ph == PH_DISP) ? hc[XW-1:0] : '0;
                y           <= (v_ph == PH_DISP) ? vc[YW-1:0] : '0;
                h_state     <= h_ph;
                v_state     <= v_ph;
                line_start  <= at_line_start;
                frame_start <= at_frame_start;

                if (h_last) begin
                    hc   <= '0;
                    h_ph <= h_ph + 2'd1;
                    // Vertical position steps only on the last tick of a line.
                    if (h_ph == PH_FP) begin
                        if (v_last) begin
                            vc   <= '0;
                            v_ph <= v_ph + 2'd1;
                        end else begin
                            vc <= vc + 1'b1;
                        end
                    end
                end else begin
                    hc <= hc + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    localparam int HA = 10, HF = 2, HS = 3, HB = 4;
    localparam int VA = 5,  VF = 2, VS = 1, VB = 3;
    localparam bit HP = 1'b1, VP = 1'b0;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FT = HT * VT;
    localparam int XW = $clog2(HA);
    localparam int YW = $clog2(VA);

    logic clk = 1'b0;
    logic rst, en;
    logic hsync, vsync, de, line_start, frame_start;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [1:0] h_state, v_state;
    logic [15:0] frame_cnt_obs;
`ifdef VGA_TIMING_FRAMECNT_EN
    logic [15:0] frame_cnt;
    assign frame_cnt_obs = frame_cnt;
`else
    assign frame_cnt_obs = 16'd0;
`endif

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(HP), .VSYNC_POL(VP)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
        .h_state(h_state), .v_state(v_state),
        .line_start(line_start), .frame_start(frame_start)
`ifdef VGA_TIMING_FRAMECNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          hsync;
        logic          vsync;
        logic          de;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [1:0]    hs;
        logic [1:0]    vs;
        logic          ls;
        logic          fs;
        logic [15:0]   fc;
    } obs_t;

    obs_t q[$];
    int checks = 0;
    int errors = 0;

    longint t;
    bit started;
    logic [15:0] fc_m;
    obs_t last;

    // Map an offset within a line/frame onto (phase, offset within phase).
    function automatic logic [1:0] seg_ph(input int p, input int a, input int b, input int c);
        if (p < a) return 2'd0;
        else if (p < a + b) return 2'd1;
        else if (p < a + b + c) return 2'd2;
        else return 2'd3;
    endfunction

    function automatic obs_t decode(input longint tt);
        obs_t d;
        int hp, ln;
        logic [1:0] hph, vph;
        hp  = int'(tt % HT);
        ln  = int'((tt / HT) % VT);
        hph = seg_ph(hp, HS, HB, HA);
        vph = seg_ph(ln, VS, VB, VA);
        d.hsync = (hph == 2'd0) ? HP : ~HP;
        d.vsync = (vph == 2'd0) ? VP : ~VP;
        d.de    = (hph == 2'd2) && (vph == 2'd2);
        d.x     = (hph == 2'd2) ? XW'(hp - HS - HB) : '0;
        d.y     = (vph == 2'd2) ? YW'(ln - VS - VB) : '0;
        d.hs    = hph;
        d.vs    = vph;
        d.ls    = (hp == 0);
        d.fs    = (hp == 0) && (ln == 0);
        d.fc    = 16'd0;
        return d;
    endfunction

    task automatic step(input bit r, input bit e);
        obs_t d;
        rst = r;
        en  = e;
        if (r) begin
            d = '{hsync: HP, vsync: VP, default: '0};
            t = 0;
            started = 1'b0;
            fc_m = 16'd0;
            last = d;
        end else if (e) begin
            d = decode(t);
            if (d.fs) begin
                if (started) fc_m = fc_m + 16'd1;
                else started = 1'b1;
            end
            d.fc = fc_m;
            last = d;
            t++;
        end else begin
            d = last;
            d.ls = 1'b0;
            d.fs = 1'b0;
        end
`ifndef VGA_TIMING_FRAMECNT_EN
        d.fc = 16'd0;
`endif
        q.push_back(d);
        @(negedge clk);
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{hsync: hsync, vsync: vsync, de: de, x: x, y: y,
                      hs: h_state, vs: v_state, ls: line_start,
                      fs: frame_start, fc: frame_cnt_obs};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t actual hs=%b vs=%b de=%b x=%0d y=%0d hph=%0d vph=%0d ls=%b fs=%b fc=%0d required hs=%b vs=%b de=%b x=%0d y=%0d hph=%0d vph=%0d ls=%b fs=%b fc=%0d",
                             $time, a.hsync, a.vsync, a.de, a.x, a.y, a.hs, a.vs, a.ls, a.fs, a.fc,
                             e.hsync, e.vsync, e.de, e.x, e.y, e.hs, e.vs, e.ls, e.fs, e.fc);
                end
            end
        end
    end

    initial begin : stimulus
        bit r;
        repeat (3) step(1'b1, 1'b0);
        repeat (2 * FT + 30) step(1'b0, 1'b1);
        // Reset mid-frame with en high, then restart.
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        repeat (FT + 20) step(1'b0, 1'b1);
        repeat (900) step(1'b0, $urandom_range(0, 3) == 0);
        repeat (1500) begin
            r = ($urandom_range(0, 299) == 0);
            step(r, 1'(($urandom_range(0, 1))));
        end
        step(1'b1, 1'b0);
        repeat (4 * FT + 5) step(1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual %0d pending required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator producing sync, data-enable, active-area pixel coordinates and per-line/per-frame strobes. Runs on the system clock with a pixel-clock enable, so one generator serves any mode whose pixel rate divides the system clock. Sits between the clock domain root and the pixel pipeline (tile/sprite renderer, colour mux) and drives the VGA connector's HS/VS pins.

## Interface

- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixel ticks)
- H_SYNC, 96, horizontal sync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HSYNC_POL, 0, level of `hsync` during sync (0 = active-low)
- VSYNC_POL, 0, level of `vsync` during sync
- Derived: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise; XW = $clog2(H_ACTIVE); YW = $clog2(V_ACTIVE)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  pixel tick enable; the raster advances only on cycles with `en`=1
- hsync  out  1  horizontal sync, polarity per HSYNC_POL
- vsync  out  1  vertical sync, polarity per VSYNC_POL
- de  out  1  high when both h and v are in Display
- x  out  XW  active column, 0..H_ACTIVE-1; 0 outside h Display
- y  out  YW  active line, 0..V_ACTIVE-1; 0 outside v Display
- h_state  out  2  horizontal phase
- v_state  out  2  vertical phase
- line_start  out  1  one-cycle strobe, first tick of each line
- frame_start  out  1  one-cycle strobe, first tick of each frame
- frame_cnt  out  16  frame counter (only with VGA_TIMING_FRAMECNT_EN)

## Operation

- Phase encoding (h and v): 2'd0 Sync, 2'd1 BackPorch, 2'd2 Display, 2'd3 FrontPorch. Order Sync -> BackPorch -> Display -> FrontPorch -> Sync.
- Horizontal: internal counter `hc` counts 0..len-1 within the current phase (len = H_SYNC/H_BP/H_ACTIVE/H_FP); on an enabled tick with `hc`=len-1, `hc` <= 0 and phase advances. Each phase lasts exactly len ticks; line = H_TOTAL ticks (800 default).
- Vertical: `vc` and v phase advance only on the enabled tick ending h FrontPorch (last tick of a line); same rule with V lengths; frame = V_TOTAL lines (525 default).
- Line/frame boundary on the same tick: both advance together; v wrap from FrontPorch to Sync coincides with h wrap.
- Decode: hsync = HSYNC_POL when h phase = Sync else ~HSYNC_POL (vsync likewise); de = (h==Display)&&(v==Display); x = hc in h Display else 0; y = vc in v Display else 0.
- line_start = position is h Sync, hc=0. frame_start = line_start && v Sync && vc=0.
- `en`=0: counters, phases and all level outputs hold; strobes are 0.
- Counter widths sized for the largest segment; no truncation permitted for any parameter set with all lengths >= 1.

## Timing

- Outputs registered: on an enabled tick, outputs take the decode of the current position, and position advances. Latency one clk from position to outputs.
- Strobes high for exactly one clk (the cycle after the enabled tick that decoded them), cleared next clk regardless of `en`.
- Reset (rst=1 at edge, dominates `en`): position = h Sync/hc=0, v Sync/vc=0; outputs: hsync=HSYNC_POL, vsync=VSYNC_POL, de=0, x=0, y=0, h_state=0, v_state=0, line_start=0, frame_start=0, frame_cnt=0.
- First enabled tick after reset: frame_start=1, line_start=1, outputs decode Sync/Sync.
- Reset mid-frame: takes effect at that edge; no partial strobe emitted.

## Configuration

- VGA_TIMING_FRAMECNT_EN defined: `frame_cnt` port present; increments (mod 2^16, wraps 65535->0) in the same cycle `frame_start` is asserted, excluding the first frame after reset (first frame reads 0, second 1).
- Undefined: port and counter absent; all other behaviour identical.

## Test plan

- Defaults, en=1 always: hsync low for 96 consecutive clks, period 800; first de=1 at clk 145 after reset release (96+48 ticks +1 latency); x runs 0..639 then de=0.
- Defaults: vsync low for 2x800 clks, period 420000 clks; frame_start spacing 420000; line_start spacing 800; y 0..479 during de.
- en pulsed 1-of-4: all periods scale x4 (line 3200 clks); strobes still exactly 1 clk wide; outputs stable across en=0 cycles.
- HSYNC_POL=1, VSYNC_POL=1, H_ACTIVE=8, H_FP=H_SYNC=H_BP=1, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1: hsync high 1 of 11 ticks, frame = 77 ticks, x 0..7, y 0..3.
- rst asserted at x=300,y=200 with en=1: next cycle all outputs at reset values; first enabled tick after release gives frame_start=1.
- VGA_TIMING_FRAMECNT_EN: after 3 frame_start strobes frame_cnt=2; forced past 65535 wraps to 0.
